// File: rtl/fifo_word_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_word_packer_if
//
// Purpose: bundles every non-clock signal of fifo_word_packer. The upstream
// side reads the show-ahead head of a byte FIFO; the downstream side is a
// valid/ready word stream.
//
// Signals:
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO head entry (valid while fifo_empty=0)
//   fifo_rd_en  pop strobe, one entry consumed per cycle it is high
//   flush       single-cycle request to emit the current partial word
//   out_valid   output word valid
//   out_ready   downstream accepts the word
//   out_data    packed word, lane 0 in the least significant IN_WIDTH bits
//   out_keep    per-lane valid bits
//   lane_cnt    lanes currently held in the accumulator (status)
//
// Modports:
//   master  the packer itself
//   slave   the environment around it (FIFO + consumer + flush source)
// -----------------------------------------------------------------------------
interface fifo_word_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = $clog2(RATIO);

    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_data;
    logic                 fifo_rd_en;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [RATIO-1:0]     out_keep;
    logic [LANE_W:0]      lane_cnt;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_keep, lane_cnt
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_keep, lane_cnt
    );
endinterface

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Purpose: reads a show-ahead byte FIFO and packs RATIO consecutive entries
// into one wide word presented on a valid/ready stream. A partially filled
// word can be pushed out with the flush input; the emitted word then carries
// keep bits only for the lanes that were filled, unfilled lanes are zero.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_word_packer_if.master (FIFO read side, flush, output stream,
//          lane_cnt status)
//
// Optional build macro:
//   PACKER_TIMEOUT_EN  when defined, a partial word that sees no pop for
//                      TIMEOUT_CYCLES consecutive cycles is flushed as if the
//                      flush input had been pulsed. When undefined, partial
//                      words leave only via the flush input.
//
// Output handshake: a word transfers on a rising clock edge where out_valid
// and out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_keep are held. A new word may load on the same edge as a
// transfer, so out_valid can stay high across back-to-back words.
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int IN_WIDTH       = 8,
    parameter int RATIO          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_word_packer_if.master bus
);
    localparam int LANE_W = $clog2(RATIO);
    localparam logic [LANE_W:0] LAST_LANE = (LANE_W + 1)'(RATIO - 1);

    if (RATIO < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fifo_word_packer: RATIO must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // Accumulator and output register.
    logic [RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d;
    logic [LANE_W:0]                lane_cnt_q, lane_cnt_d;
    logic                           flush_pending_q, flush_pending_d;
    logic                           out_valid_q, out_valid_d;
    logic [RATIO-1:0][IN_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]               out_keep_q, out_keep_d;

    logic                           out_free;
    logic                           pop;
    logic                           pop_last;
    logic                           flush_load;
    logic                           word_load;
    logic                           flush_req;
    logic                           timeout_flush;
    logic [LANE_W:0]                fill_cnt;
    logic [RATIO-1:0][IN_WIDTH-1:0] merged;

    // Pop control. The only stall is at the final lane: completing a word
    // needs the output register to be free on that same edge.
    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        pop        = rst_n && !bus.fifo_empty && !((lane_cnt_q == LAST_LANE) && !out_free);
        pop_last   = pop && (lane_cnt_q == LAST_LANE);
        flush_load = flush_pending_q && out_free;
        word_load  = pop_last || flush_load;
        fill_cnt   = lane_cnt_q + {{LANE_W{1'b0}}, pop};
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Counts cycles a partial word sits without a pop. On firing it restarts
    // so the internal flush is a single-cycle pulse like the flush input.
    always_comb begin
        timeout_flush = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));
        idle_cnt_d    = idle_cnt_q;
        if (pop || flush_load || timeout_flush) begin
            idle_cnt_d = '0;
        end else if (lane_cnt_q != '0) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    always_comb begin
        timeout_flush = 1'b0;
    end
`endif

    always_comb begin
        flush_req = bus.flush || timeout_flush;

        // The byte popped this cycle joins whatever word loads on this edge,
        // including a flushed partial word.
        merged = acc_q;
        if (pop) begin
            merged[lane_cnt_q[LANE_W-1:0]] = bus.fifo_data;
        end

        acc_d           = merged;
        lane_cnt_d      = fill_cnt;
        flush_pending_d = flush_pending_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_keep_d      = out_keep_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (word_load) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < RATIO; i++) begin
                out_keep_d[i] = (i < int'(fill_cnt));
                out_data_d[i] = out_keep_d[i] ? merged[i] : '0;
            end
            lane_cnt_d = '0;
        end

        // A flush landing on an edge that already emits a word has nothing
        // left to flush, so it is absorbed; this keeps empty words impossible.
        if (word_load) begin
            flush_pending_d = 1'b0;
        end else if (flush_req && ((lane_cnt_q != '0) || pop)) begin
            flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q           <= '0;
            lane_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_keep_q      <= '0;
        end else begin
            acc_q           <= acc_d;
            lane_cnt_q      <= lane_cnt_d;
            flush_pending_q <= flush_pending_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_keep_q      <= out_keep_d;
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_keep   = out_keep_q;
    assign bus.lane_cnt   = lane_cnt_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Bench for fifo_word_packer with IN_WIDTH=8, RATIO=4. The upstream FIFO is a
// byte queue; expected words are built by grouping pushed bytes into fours
// (or into the partial group present at a flush) with lane 0 in the low byte.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_word_packer;
    localparam int IN_WIDTH       = 8;
    localparam int RATIO          = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int OUT_WIDTH      = IN_WIDTH * RATIO;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_word_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    fifo_word_packer #(
        .IN_WIDTH      (IN_WIDTH),
        .RATIO         (RATIO),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [IN_WIDTH-1:0]  fifo_q[$];
    logic [OUT_WIDTH-1:0] got_data_q[$];
    logic [RATIO-1:0]     got_keep_q[$];
    logic [OUT_WIDTH-1:0] exp_q[$];

    // FIFO model and output monitor. Pops and captures use pre-edge values;
    // the FIFO head is refreshed 1ns after every clock edge.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_q.delete(0);
            if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_data_q.push_back(bus.out_data);
                got_keep_q.push_back(bus.out_keep);
            end
        end
        #1;
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [IN_WIDTH-1:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        fifo_q.delete();
        repeat (2) @(negedge clk);
        got_data_q.delete();
        got_keep_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        push_byte(8'h5A);
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.lane_cnt !== 3'd0) begin errors++; $display("FAIL reset_lane_cnt: got %0d expected 0", bus.lane_cnt); end
        checks++; if (bus.out_keep !== 4'b0000) begin errors++; $display("FAIL reset_keep: got %b expected 0000", bus.out_keep); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.out_data); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        fifo_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous_fill();
        do_reset();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        repeat (3) @(negedge clk);
        checks++; if (bus.lane_cnt !== 3'd3) begin errors++; $display("FAIL fill_lane_cnt3: got %0d expected 3", bus.lane_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid: got %b expected 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL fill_data: got %h expected 44332211", bus.out_data); end
        checks++; if (bus.out_keep !== 4'b1111) begin errors++; $display("FAIL fill_keep: got %b expected 1111", bus.out_keep); end
        checks++; if (bus.lane_cnt !== 3'd0) begin errors++; $display("FAIL fill_lane_cnt0: got %0d expected 0", bus.lane_cnt); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_drop: got %b expected 0", bus.out_valid); end
        checks++; if (got_data_q.size() != 1) begin errors++; $display("FAIL fill_count: got %0d expected 1", got_data_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 17));
        repeat (4) @(negedge clk);
        checks++; if (bus.out_data !== 32'h44332211 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got %b/%h expected 1/44332211", bus.out_valid, bus.out_data); end
        repeat (3) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_data !== 32'h44332211 || bus.out_valid !== 1'b1 || bus.fifo_rd_en !== 1'b0) begin
                errors++; $display("FAIL bp_hold: got valid=%b data=%h rd_en=%b expected 1/44332211/0", bus.out_valid, bus.out_data, bus.fifo_rd_en);
            end
        end
        checks++; if (bus.lane_cnt !== 3'd3) begin errors++; $display("FAIL bp_lane_cnt: got %0d expected 3", bus.lane_cnt); end
        checks++; if (fifo_q.size() != 1) begin errors++; $display("FAIL bp_pop_count: got %0d left expected 1", fifo_q.size()); end
        bus.out_ready = 1'b1;
        #2;
        checks++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL bp_release_rd_en: got %b expected 1", bus.fifo_rd_en); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h88776655) begin errors++; $display("FAIL bp_second: got %b/%h expected 1/88776655", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_keep !== 4'b1111) begin errors++; $display("FAIL bp_second_keep: got %b expected 1111", bus.out_keep); end
        @(negedge clk);
        checks++; if (got_data_q.size() != 2 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d words valid=%b expected 2 words valid=0", got_data_q.size(), bus.out_valid); end
    endtask

    task automatic test_partial_flush();
        int n;
        do_reset();
        push_byte(8'hAA); push_byte(8'hBB);
        repeat (2) @(negedge clk);
        checks++; if (bus.lane_cnt !== 3'd2) begin errors++; $display("FAIL pflush_lane_cnt2: got %0d expected 2", bus.lane_cnt); end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pflush_timeout: got valid=%b expected 1 within 8 cycles", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0000BBAA) begin errors++; $display("FAIL pflush_data: got %h expected 0000bbaa", bus.out_data); end
        checks++; if (bus.out_keep !== 4'b0011) begin errors++; $display("FAIL pflush_keep: got %b expected 0011", bus.out_keep); end
        checks++; if (bus.lane_cnt !== 3'd0) begin errors++; $display("FAIL pflush_lane_cnt0: got %0d expected 0", bus.lane_cnt); end
        repeat (5) @(negedge clk);
        checks++; if (got_data_q.size() != 1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL pflush_extra: got %0d words expected 1", got_data_q.size()); end
    endtask

    task automatic test_flush_with_pop();
        int n;
        do_reset();
        push_byte(8'h01);
        @(negedge clk);
        checks++; if (bus.lane_cnt !== 3'd1) begin errors++; $display("FAIL fpop_lane_cnt1: got %0d expected 1", bus.lane_cnt); end
        push_byte(8'h02);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (bus.out_data !== 32'h00000201 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL fpop_data: got %b/%h expected 1/00000201", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_keep !== 4'b0011) begin errors++; $display("FAIL fpop_keep: got %b expected 0011", bus.out_keep); end
    endtask

    task automatic test_flush_ignored();
        do_reset();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || got_data_q.size() != 0) begin errors++; $display("FAIL fign_empty_word: got valid=%b words=%0d expected 0/0", bus.out_valid, got_data_q.size()); end
    endtask

    task automatic test_flush_absorbed();
        do_reset();
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        repeat (3) @(negedge clk);
        push_byte(8'hC4);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.out_data !== 32'hC4C3C2C1 || bus.out_keep !== 4'b1111) begin errors++; $display("FAIL fabs_word: got %h/%b expected c4c3c2c1/1111", bus.out_data, bus.out_keep); end
        repeat (5) @(negedge clk);
        checks++; if (got_data_q.size() != 1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fabs_extra: got %0d words expected 1", got_data_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(8'h10 + i));
        repeat (8) @(negedge clk);
        checks++; if (bus.lane_cnt !== 3'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup: got lane_cnt=%0d valid=%b expected 3/1", bus.lane_cnt, bus.out_valid); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.lane_cnt !== 3'd0) begin errors++; $display("FAIL rmid_lane_cnt: got %0d expected 0", bus.lane_cnt); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_rd_en: got %b expected 0", bus.fifo_rd_en); end
        @(negedge clk);
        fifo_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
        repeat (4) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA4A3A2A1 || bus.out_keep !== 4'b1111) begin errors++; $display("FAIL rmid_clean: got %b/%h/%b expected 1/a4a3a2a1/1111", bus.out_valid, bus.out_data, bus.out_keep); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        push_byte(8'h5A);
        @(negedge clk);
`ifdef PACKER_TIMEOUT_EN
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000005A || bus.out_keep !== 4'b0001) begin errors++; $display("FAIL tmo_word: got %b/%h/%b expected 1/0000005a/0001", bus.out_valid, bus.out_data, bus.out_keep); end
        checks++; if (n < TIMEOUT_CYCLES || n > TIMEOUT_CYCLES + 4) begin errors++; $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d", n, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 4); end
`else
        n = 0;
        repeat (30) begin @(negedge clk); if (bus.out_valid === 1'b1) n++; end
        checks++; if (n != 0 || bus.lane_cnt !== 3'd1) begin errors++; $display("FAIL tmo_none: got %0d valid cycles lane_cnt=%0d expected 0/1", n, bus.lane_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        int valid_cycles;
        logic [OUT_WIDTH-1:0] w;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            w = '0;
            for (int j = 0; j < RATIO; j++) begin
                logic [IN_WIDTH-1:0] b;
                b = 8'($urandom_range(0, 255));
                push_byte(b);
                w = w | (OUT_WIDTH'(b) << (IN_WIDTH * j));
            end
            exp_q.push_back(w);
        end
        valid_cycles = 0;
        repeat (17) begin @(negedge clk); if (bus.out_valid === 1'b1) valid_cycles++; end
        checks++; if (valid_cycles != 4) begin errors++; $display("FAIL b2b_rate: got %0d valid cycles expected 4", valid_cycles); end
        checks++; if (got_data_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d words expected 4", got_data_q.size()); end
        while (got_data_q.size() > 0 && exp_q.size() > 0) begin
            logic [OUT_WIDTH-1:0] g;
            logic [OUT_WIDTH-1:0] e;
            g = got_data_q.pop_front();
            e = exp_q.pop_front();
            void'(got_keep_q.pop_front());
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_word: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_random();
        localparam int N_WORDS = 48;
        logic [IN_WIDTH-1:0]  src_q[$];
        logic [OUT_WIDTH-1:0] w;
        logic [OUT_WIDTH-1:0] prev_data;
        logic                 prev_valid;
        logic                 prev_ready;
        int words_done;
        int cycles;
        do_reset();
        for (int k = 0; k < N_WORDS; k++) begin
            w = '0;
            for (int j = 0; j < RATIO; j++) begin
                logic [IN_WIDTH-1:0] b;
                b = 8'($urandom_range(0, 255));
                src_q.push_back(b);
                w = w | (OUT_WIDTH'(b) << (IN_WIDTH * j));
            end
            exp_q.push_back(w);
        end
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0;
        words_done = 0; cycles = 0;
        while (words_done < N_WORDS && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (prev_valid && !prev_ready) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    errors++; $display("FAIL rand_stable: got %b/%h expected 1/%h", bus.out_valid, bus.out_data, prev_data);
                end
            end
            while (got_data_q.size() > 0) begin
                logic [OUT_WIDTH-1:0] g;
                logic [RATIO-1:0]     gk;
                logic [OUT_WIDTH-1:0] e;
                g  = got_data_q.pop_front();
                gk = got_keep_q.pop_front();
                e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                words_done++;
                checks++; if (g !== e || gk !== 4'b1111) begin errors++; $display("FAIL rand_word%0d: got %h/%b expected %h/1111", words_done, g, gk, e); end
            end
            prev_valid    = bus.out_valid;
            prev_data     = bus.out_data;
            prev_ready    = ($urandom_range(0, 3) != 0);
            bus.out_ready = prev_ready;
            if (src_q.size() > 0 && fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push_byte(src_q.pop_front());
        end
        checks++; if (words_done != N_WORDS) begin errors++; $display("FAIL rand_timeout: got %0d words expected %0d", words_done, N_WORDS); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_continuous_fill();
        test_backpressure();
        test_partial_flush();
        test_flush_with_pop();
        test_flush_ignored();
        test_flush_absorbed();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Sits directly downstream of the team's byte FIFO, reading its show-ahead output.
- Packs RATIO consecutive narrow entries into one wide word.
- Presents each wide word on a valid/ready stream to the compute datapath.
- Supports explicit flush of a partially filled word, with per-lane keep flags.

Parameters:
- IN_WIDTH, 8: width of one FIFO entry (one lane).
- RATIO, 4: lanes per output word; must be >= 2.
- TIMEOUT_CYCLES, 16: idle cycles before auto-flush. Used only with PACKER_TIMEOUT_EN.
- Derived (localparam): OUT_WIDTH = IN_WIDTH*RATIO; LANE_W = $clog2(RATIO).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_data  input  IN_WIDTH  upstream FIFO head entry, valid whenever fifo_empty=0.
- fifo_rd_en  output  1  pop strobe to FIFO; one entry consumed per cycle it is high.
- flush  input  1  single-cycle request to emit the current partial word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  OUT_WIDTH  packed word; lane 0 in bits [IN_WIDTH-1:0].
- out_keep  output  RATIO  per-lane valid bits; all ones for full words.
- lane_cnt  output  LANE_W+1  lanes currently held in the accumulator (status).

Behaviour:
- Reset (async, rst_n low) clears: accumulator, lane_cnt, out_valid, out_data, out_keep, flush_pending. fifo_rd_en=0 while held in reset.
  - Reset asserted mid-word discards the partial word and any un-accepted output word.
- Storage: accumulator (RATIO lanes + lane_cnt) and a single output register (out_data/out_keep/out_valid).
- out_free = !out_valid || out_ready.
- fifo_rd_en (combinational) = !fifo_empty && !(lane_cnt==RATIO-1 && !out_free).
  - A pop writes fifo_data into lane lane_cnt, then lane_cnt increments.
- Word complete: a pop with lane_cnt==RATIO-1 loads the out register on that edge with keep all ones; lane_cnt returns to 0.
  - out_valid is high the cycle after the final pop.
  - Minimum latency: RATIO pops + 1 cycle.
  - Sustained throughput: one word per RATIO cycles.
- Output handshake:
  - A word transfers on a clock edge with out_valid && out_ready.
  - out_data/out_keep are held stable while out_valid && !out_ready.
  - out_valid drops after transfer unless a new word loads on the same edge (back-to-back allowed).
- Flush:
  - flush with lane_cnt>0, or with a pop in the same cycle, sets flush_pending.
  - flush with lane_cnt==0 and no pop is ignored.
  - While flush_pending and out_free: load the accumulator's filled lanes into the out register, set keep bits only for those lanes, zero the remaining lanes, clear lane_cnt and flush_pending.
  - A pop in the same cycle as that load goes into the flushed word, not the next one.
  - A flush coinciding with a word-completing pop is absorbed; no empty word is ever emitted.
- Simultaneous events:
  - Pop into lane 0 on the same edge as a flush load: the byte is included in the flushed word.
  - Pops are never stalled except at the final-lane rule above.
- No arithmetic overflow possible: lane_cnt range is 0..RATIO-1 between edges.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle with lane_cnt>0 and no pop.
  - It clears on any pop or flush load.
  - On reaching TIMEOUT_CYCLES it raises an internal flush, identical to the flush port.
  - Reset clears the counter.
- Undefined: no counter logic; partial words leave only via the flush port; TIMEOUT_CYCLES is ignored.

Test Plan:
- Continuous fill: bytes 0x11,0x22,0x33,0x44 available, out_ready=1 -> one word 0x44332211, keep 4'b1111, out_valid one cycle after 4th pop.
- Backpressure: 8 bytes queued, out_ready=0 -> first word held stable, exactly 3 more pops then fifo_rd_en=0; raise out_ready -> 4th pop completes, second word 0x88776655 follows.
- Partial flush: pop 0xAA,0xBB then flush -> out_data=0x0000BBAA, keep 4'b0011, lane_cnt=0.
- Flush with pop in same cycle: lane_cnt=1 (0x01), flush while popping 0x02 -> word 0x00000201, keep 4'b0011.
- Reset mid-operation: 3 lanes filled and an output word pending, assert rst_n=0 -> out_valid=0, lane_cnt=0, fifo_rd_en=0; after release, the next 4 bytes form a clean word.
- PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=16: pop 1 byte 0x5A then FIFO empty -> out_valid rises with 0x0000005A, keep 4'b0001, after 16 idle cycles; without macro, none.
